// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue
//
// Instruction fetch front end with a small prefetch queue between the
// instruction memory and decode. It requests one word per cycle while the
// queue has room, then pushes each response together with its next-PC into
// a circular FIFO. The head of the FIFO is shown to decode combinationally.
// A taken branch (redirect) flushes the queue, drops any response still in
// flight and restarts fetching at the branch target.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  word address fetched first after reset
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   redirect_valid  taken branch from execute: flush and refetch
//   redirect_pc     branch target word address
//   imem_req        instruction memory read strobe
//   imem_addr       word address into the 1024x32 instruction memory
//   imem_rdata      read data, valid one cycle after imem_req
//   id_valid        head entry available to decode
//   id_ready        decode accepts the head entry
//   id_ir           head instruction word
//   id_npc          head instruction address + 1
//   pc              next word address to request
//   count           current queue occupancy
module mips32_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [9:0]               imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_ir,
    output logic [31:0]              id_npc,
    output logic [31:0]              pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_reg;
    logic [31:0]   pc_next;
    logic          inflight_reg;
    logic [31:0]   req_npc_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW:0]   occupancy;
    logic          push;
    logic          pop;

    logic [31:0]   ir_mem  [DEPTH];
    logic [31:0]   npc_mem [DEPTH];

    // Entries already queued plus the one whose data arrives next cycle;
    // counting the in-flight word is what keeps the queue from overflowing.
    assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};

    assign imem_req  = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = pc_reg[9:0];
    assign pc        = pc_reg;
    assign count     = count_reg;

    // Redirect hides the head so decode never consumes a wrong-path word.
    assign id_valid  = (count_reg != '0) && !redirect_valid;
    assign id_ir     = ir_mem[rd_ptr_reg];
    assign id_npc    = npc_mem[rd_ptr_reg];

    // A response arriving in the redirect cycle belongs to the old path.
    assign push = inflight_reg && !redirect_valid;
    assign pop  = id_valid && id_ready;

    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (imem_req) begin
            pc_next = pc_reg + 32'd1;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (redirect_valid) begin
            count_next = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            inflight_reg <= 1'b0;
            req_npc_reg  <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            pc_reg       <= pc_next;
            inflight_reg <= imem_req;
            count_reg    <= count_next;
            if (imem_req) begin
                req_npc_reg <= pc_reg + 32'd1;
            end
            if (redirect_valid) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap naturally.
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
            end
        end
    end

    // Queue storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr_reg]  <= imem_rdata;
            npc_mem[wr_ptr_reg] <= req_npc_reg;
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_reg == CW'(DEPTH))));

endmodule

// File: tb/tb_mips32_fetch_queue.sv
module tb_mips32_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_npc;
    logic [31:0] pc;
    logic [2:0]  count;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mem [1024];
    logic [31:0] exp_ir [4];

    mips32_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'd0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_npc         (id_npc),
        .pc             (pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the strobe.
    always @(posedge clk) begin
        if (imem_req) begin
            imem_rdata <= mem[imem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'hA000_0000 | 32'(i);
        end
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;
        exp_ir[0] = 32'h11;
        exp_ir[1] = 32'h22;
        exp_ir[2] = 32'h33;
        exp_ir[3] = 32'h44;
        imem_rdata     = 32'h0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;

        // Reset state
        step(2);
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_count", 32'(count),    32'd0);
        chk("rst_pc",    pc,            32'd0);

        // Streaming with decode always ready
        rst_n = 1'b1;
        #1;
        chk("s_req0",  32'(imem_req),  32'd1);
        chk("s_addr0", 32'(imem_addr), 32'd0);
        chk("s_val0",  32'(id_valid),  32'd0);
        step(1);
        chk("s_val1",  32'(id_valid),  32'd0);
        chk("s_pc1",   pc,             32'd1);
        chk("s_addr1", 32'(imem_addr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("s_valid", 32'(id_valid), 32'd1);
            chk("s_ir",    id_ir,         exp_ir[i]);
            chk("s_npc",   id_npc,        32'(i + 1));
            chk("s_count", 32'(count),    32'd1);
        end

        // Fill with decode stalled
        rst_n = 1'b0;
        #1;
        chk("r2_count", 32'(count),    32'd0);
        chk("r2_valid", 32'(id_valid), 32'd0);
        id_ready = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(4);
        chk("f_pc4",    pc,            32'd4);
        chk("f_cnt3",   32'(count),    32'd3);
        chk("f_req0",   32'(imem_req), 32'd0);
        step(1);
        chk("f_cnt4",   32'(count),    32'd4);
        chk("f_req",    32'(imem_req), 32'd0);
        chk("f_pc",     pc,            32'd4);
        chk("f_ir",     id_ir,         32'h11);
        chk("f_npc",    id_npc,        32'd1);
        step(1);
        chk("f_hold_ir",  id_ir,       32'h11);
        chk("f_hold_cnt", 32'(count),  32'd4);
        id_ready = 1'b1;
        step(1);
        chk("f_pop_cnt", 32'(count),     32'd3);
        chk("f_pop_ir",  id_ir,          32'h22);
        chk("f_rq",      32'(imem_req),  32'd1);
        chk("f_rq_addr", 32'(imem_addr), 32'd4);
        id_ready = 1'b0;
        step(2);
        chk("f_refill_cnt", 32'(count),    32'd4);
        chk("f_refill_pc",  pc,            32'd5);
        chk("f_refill_req", 32'(imem_req), 32'd0);
        chk("f_refill_ir",  id_ir,         32'h22);
        chk("f_refill_npc", id_npc,        32'd2);

        // Drain down to steady push+pop at count 2
        id_ready = 1'b1;
        step(1);
        chk("d_cnt3", 32'(count), 32'd3);
        chk("d_ir3",  id_ir,      32'h33);
        step(1);
        chk("d_cnt2", 32'(count), 32'd2);
        chk("d_ir2",  id_ir,      32'h44);
        step(1);
        chk("pp_cnt_a", 32'(count), 32'd2);
        chk("pp_ir_a",  id_ir,      32'hA000_0004);
        chk("pp_npc_a", id_npc,     32'd5);
        step(1);
        chk("pp_cnt_b", 32'(count), 32'd2);
        chk("pp_ir_b",  id_ir,      32'hA000_0005);
        chk("pp_npc_b", id_npc,     32'd6);

        // Redirect with count 3 and a word in flight
        id_ready = 1'b0;
        step(1);
        chk("rd_pre_cnt", 32'(count),    32'd3);
        chk("rd_pre_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        #1;
        chk("rd_req",   32'(imem_req), 32'd0);
        chk("rd_valid", 32'(id_valid), 32'd0);
        step(1);
        redirect_valid = 1'b0;
        #1;
        chk("rd_cnt0",  32'(count),     32'd0);
        chk("rd_req1",  32'(imem_req),  32'd1);
        chk("rd_addr",  32'(imem_addr), 32'h20);
        chk("rd_val0",  32'(id_valid),  32'd0);
        step(1);
        chk("rd_discard_cnt", 32'(count),    32'd0);
        chk("rd_discard_val", 32'(id_valid), 32'd0);
        step(1);
        chk("rd_valid2", 32'(id_valid), 32'd1);
        chk("rd_ir",     id_ir,         32'hA000_0020);
        chk("rd_npc",    id_npc,        32'h21);
        chk("rd_cnt1",   32'(count),    32'd1);

        // Address wrap at the top of the instruction memory
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FF;
        step(1);
        redirect_valid = 1'b0;
        #1;
        chk("w_addr_a", 32'(imem_addr), 32'h3FF);
        chk("w_pc_a",   pc,             32'h3FF);
        chk("w_cnt",    32'(count),     32'd0);
        step(1);
        chk("w_addr_b", 32'(imem_addr), 32'h000);
        chk("w_pc_b",   pc,             32'h400);
        step(1);
        chk("w_ir_a",  id_ir,  32'hA000_03FF);
        chk("w_npc_a", id_npc, 32'h400);
        step(1);
        chk("w_ir_b",  id_ir,  32'h11);
        chk("w_npc_b", id_npc, 32'h401);

        // Short asynchronous reset pulse with a full queue
        id_ready = 1'b0;
        step(4);
        chk("a_pre_cnt", 32'(count),    32'd4);
        chk("a_pre_val", 32'(id_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_val", 32'(id_valid), 32'd0);
        chk("a_cnt", 32'(count),    32'd0);
        chk("a_req", 32'(imem_req), 32'd0);
        chk("a_pc",  pc,            32'd0);
        rst_n    = 1'b1;
        id_ready = 1'b1;
        #1;
        chk("a_req1",  32'(imem_req),  32'd1);
        chk("a_addr0", 32'(imem_addr), 32'd0);
        step(1);
        chk("a_val_e1", 32'(id_valid), 32'd0);
        step(1);
        chk("a_val_e2", 32'(id_valid), 32'd1);
        chk("a_ir",     id_ir,         32'h11);
        chk("a_npc",    id_npc,        32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
